// File: rtl/uart_bit_timer_if.sv
// Frame request / bit-timing handshake between the TX shift register (master)
// and the bit timer (slave).
interface uart_bit_timer_if;
  logic       start;
  logic       abort;
  logic [1:0] baud_sel;
  logic       tick;
  logic       mid_tick;
  logic [3:0] bit_idx;
  logic       busy;
  logic       done;

  modport master (output start, abort, baud_sel,
                  input  tick, mid_tick, bit_idx, busy, done);
  modport slave  (input  start, abort, baud_sel,
                  output tick, mid_tick, bit_idx, busy, done);
endinterface

// File: rtl/uart_bit_timer.sv
// UART TX bit-timing generator: one tick per bit period over FRAME_BITS bits.
// Optional mid-bit pulse enabled by defining UART_BIT_TIMER_MID_EN.
module uart_bit_timer #(
  parameter int DIV0       = 5208,
  parameter int DIV1       = 2604,
  parameter int DIV2       = 868,
  parameter int DIV3       = 434,
  parameter int CNT_W      = 13,
  parameter int FRAME_BITS = 11
) (
  input  logic            clk_50M,
  input  logic            reset_n,
  uart_bit_timer_if.slave bus
);
  // div_r is one bit wider than the counter so a divisor of 2^CNT_W fits.
  localparam int DW = CNT_W + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_r, state_nx;
  logic [CNT_W-1:0]  cnt_r;
  logic [DW-1:0]     div_r, sel_div;
  logic [3:0]        idx_r;
  logic              done_r;
  logic              busy, tick, mid, accept, last;

  always_comb begin
    sel_div = DW'(DIV0);
    case (bus.baud_sel)
      2'd0: sel_div = DW'(DIV0);
      2'd1: sel_div = DW'(DIV1);
      2'd2: sel_div = DW'(DIV2);
      2'd3: sel_div = DW'(DIV3);
      default: sel_div = DW'(DIV0);
    endcase
  end

  always_ff @(posedge clk_50M or negedge reset_n)
    if (!reset_n) state_r <= IDLE;
    else          state_r <= state_nx;

  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE: if (accept)       state_nx = RUN;
      RUN:  if (bus.abort || last) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_r == RUN);
    tick   = busy && ({1'b0, cnt_r} == div_r - DW'(1));
    accept = !busy && bus.start && !bus.abort;
    last   = tick && (idx_r == 4'(FRAME_BITS - 1));
`ifdef UART_BIT_TIMER_MID_EN
    mid    = busy && ({1'b0, cnt_r} == (div_r >> 1) - DW'(1));
`else
    mid    = 1'b0;
`endif
  end

  always_ff @(posedge clk_50M or negedge reset_n)
    if (!reset_n) begin
      cnt_r  <= '0;
      idx_r  <= '0;
      div_r  <= DW'(DIV0);
      done_r <= 1'b0;
    end else begin
      // abort beats the final tick, so a cancelled frame never reports done
      done_r <= last && !bus.abort;
      if (accept) begin
        div_r <= sel_div;
        cnt_r <= '0;
        idx_r <= '0;
      end else if (busy) begin
        if (bus.abort || last) begin
          cnt_r <= '0;
          idx_r <= '0;
        end else if (tick) begin
          cnt_r <= '0;
          idx_r <= idx_r + 4'd1;
        end else begin
          cnt_r <= cnt_r + CNT_W'(1);
        end
      end
    end

  assign bus.tick     = tick;
  assign bus.mid_tick = mid;
  assign bus.bit_idx  = idx_r;
  assign bus.busy     = busy;
  assign bus.done     = done_r;
endmodule

// File: tb/tb_uart_bit_timer.sv
// Bench for uart_bit_timer: directed frames plus random start/abort traffic,
// checked against a cycle-numbered frame model.
module tb_uart_bit_timer;
  localparam int FB = 11;
  int divs [4] = '{10, 6, 2, 4};

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  uart_bit_timer_if bif();

  uart_bit_timer #(.DIV0(10), .DIV1(6), .DIV2(2), .DIV3(4), .CNT_W(13), .FRAME_BITS(FB))
    dut (.clk_50M(clk), .reset_n(reset_n), .bus(bif));

  always #10 clk = ~clk;

  int errs = 0, checks = 0;
  int cyc = 0;
  bit m_act = 0;
  int m_t0 = 0, m_d = 10, m_done_at = -1;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".tick"}, int'(bif.tick), 0);
    chk({tag, ".mid"},  int'(bif.mid_tick), 0);
    chk({tag, ".idx"},  int'(bif.bit_idx), 0);
    chk({tag, ".busy"}, int'(bif.busy), 0);
    chk({tag, ".done"}, int'(bif.done), 0);
  endtask

  // One clock cycle: drive inputs, check outputs at negedge against the model,
  // then advance the model with the inputs the DUT samples at the next posedge.
  task automatic step(input bit s, input bit a, input logic [1:0] sel);
    int rel;
    bit e_tick, e_mid, e_busy, e_done;
    int e_idx;
    bif.start = s; bif.abort = a; bif.baud_sel = sel;
    @(negedge clk);
    rel = cyc - m_t0;
    e_tick = 0; e_mid = 0; e_busy = 0; e_idx = 0;
    if (m_act) begin
      e_busy = 1;
      e_tick = (rel % m_d) == 0;
      e_idx  = (rel - 1) / m_d;
      e_mid  = ((rel - 1) % m_d) == (m_d / 2 - 1);
    end
`ifndef UART_BIT_TIMER_MID_EN
    e_mid = 0;
`endif
    e_done = (cyc == m_done_at);
    chk("tick", int'(bif.tick), int'(e_tick));
    chk("mid",  int'(bif.mid_tick), int'(e_mid));
    chk("idx",  int'(bif.bit_idx), e_idx);
    chk("busy", int'(bif.busy), int'(e_busy));
    chk("done", int'(bif.done), int'(e_done));
    if (m_act) begin
      if (a) m_act = 0;
      else if (rel == FB * m_d) begin
        m_act = 0;
        m_done_at = cyc + 1;
      end
    end else if (s && !a) begin
      m_act = 1; m_t0 = cyc; m_d = divs[sel];
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  initial begin
    bif.start = 0; bif.abort = 0; bif.baud_sel = 0;
    // reset held 5 cycles, then 100 idle cycles
    repeat (5) begin @(negedge clk); chk_zero("rst"); end
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (100) step(0, 0, 0);

    // nominal frame, divisor 10
    step(1, 0, 0);
    for (int i = 1; i < 115; i++) step(0, 0, 0);

    // baud_sel 3 latched, switch to 0 mid-frame has no effect
    step(1, 0, 3);
    for (int i = 1; i < 50; i++) step(0, 0, (i >= 5) ? 2'd0 : 2'd3);

    // ignored starts at 30/60, back-to-back start in done cycle 111
    for (int i = 0; i < 240; i++) step(i == 0 || i == 30 || i == 60 || i == 111, 0, 0);

    // abort at cycle 35
    for (int i = 0; i < 60; i++) step(i == 0, i == 35, 0);

    // abort coinciding with the final tick
    for (int i = 0; i < 115; i++) step(i == 0, i == 110, 0);

    // start with abort in idle is rejected
    step(1, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0);

    // random traffic, includes minimum divisor 2
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 7) == 0, $urandom_range(0, 99) == 0, 2'($urandom_range(0, 3)));

    // async reset mid-frame clears outputs immediately, no done afterwards
    step(1, 0, 0);
    for (int i = 0; i < 24; i++) step(0, 0, 0);
    reset_n = 1'b0; #1;
    chk_zero("arst");
    m_act = 0; m_done_at = -1;
    @(posedge clk); #1 reset_n = 1'b1;
    cyc++;
    for (int i = 0; i < 20; i++) step(0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
